seg_display_scanner: RTL and testbench

Time-multiplexed driver for the three-digit seven-segment display fed by the two-digit BCD adder's pattern outputs (d2, d1, d0). It captures the three digit patterns, and drives one shared segment bus plus three digit enables in a fixed refresh cycle. Each digit slot starts with a programmable dead time to prevent ghosting. New patterns take effect only on frame boundaries, so a frame never mixes old and new values.

---
 rtl/display_pkg.sv | 23 ++
 rtl/scan_timer.sv | 39 +++
 rtl/seg_display_scanner.sv | 132 +++++++++++++
 tb/tb_seg_display_scanner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed seven-segment display scanner.
package display_pkg;

   localparam logic [7:0] SEG_OFF_DEF  = 8'hFF;
   localparam logic [7:0] ZERO_PAT_DEF = 8'hC0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   typedef logic [1:0] slot_t;

   localparam slot_t LAST_SLOT = 2'd2;

   typedef struct packed {
      logic [7:0] p2;
      logic [7:0] p1;
      logic [7:0] p0;
   } pat_set_t;

endpackage

// File: rtl/scan_timer.sv
// Slot timer: count walks 0..TICK_DIV-1 per slot, slots go 0 -> 1 -> 2 -> 0.
module scan_timer
   import display_pkg::*;
#(
   parameter int TICK_DIV  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic [CW-1:0] count,
   output slot_t         slot,
   output logic          in_blank,
   output logic          frame_end
);

   localparam logic [CW-1:0] COUNT_MAX = CW'(TICK_DIV - 1);

   logic slot_end;

   assign slot_end  = (count == COUNT_MAX);
   assign in_blank  = (int'(count) < BLANK_CYC);
   assign frame_end = run && slot_end && (slot == LAST_SLOT);

   // Held at slot 0 / count 0 whenever not running so a restart begins a fresh frame.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         count <= '0;
         slot  <= '0;
      end else if (slot_end) begin
         count <= '0;
         slot  <= (slot == LAST_SLOT) ? slot_t'(0) : slot + slot_t'(1);
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Three-digit multiplexed seven-segment driver with dead time, frame-aligned
// pattern updates and leading-zero blanking.
//
//   state | meaning
//   IDLE  | en low, display dark, timer held at slot 0 / count 0
//   BLANK | start of a slot, dead time, all digits off
//   SHOW  | selected digit lit with its active pattern
module seg_display_scanner
   import display_pkg::*;
#(
   parameter int         TICK_DIV  = 50000,
   parameter int         BLANK_CYC = 16,
   parameter logic [7:0] SEG_OFF   = SEG_OFF_DEF,
   parameter logic [7:0] ZERO_PAT  = ZERO_PAT_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       lzb,
   input  logic       load,
   input  logic [7:0] d2,
   input  logic [7:0] d1,
   input  logic [7:0] d0,
   output logic [7:0] seg,
   output logic [2:0] an,
   output logic       frame_done,
   output logic       pending
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t        state_q, state_d;
   logic [CW-1:0] count;
   slot_t         slot;
   logic          in_blank;
   logic          frame_end;
   logic          run;

   pat_set_t      sh, ac, din;
   logic [7:0]    seg_d;
   logic [2:0]    an_d;
   logic          blank2, blank1;

   assign run = en && (state_q != IDLE);
   assign din = '{p2: d2, p1: d1, p0: d0};

   scan_timer #(
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC),
      .CW        (CW)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .count     (count),
      .slot      (slot),
      .in_blank  (in_blank),
      .frame_end (frame_end)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // The timer restarts at count 0 on leaving IDLE, so the FSM tracks it by count compares.
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
            BLANK:   if (count == CW'(BLANK_CYC - 1)) state_d = SHOW;
            SHOW:    if (count == CW'(TICK_DIV - 1) && BLANK_CYC != 0) state_d = BLANK;
            default: state_d = IDLE;
         endcase
      end
   end

   assign blank2 = lzb && (ac.p2 == ZERO_PAT);
   assign blank1 = blank2 && (ac.p1 == ZERO_PAT);

   always_comb begin
      seg_d = SEG_OFF;
      an_d  = 3'b111;
      if (state_q == SHOW && !in_blank) begin
         an_d = ~(3'b001 << slot);
         case (slot)
            2'd0:    seg_d = ac.p0;
            2'd1:    seg_d = blank1 ? SEG_OFF : ac.p1;
            2'd2:    seg_d = blank2 ? SEG_OFF : ac.p2;
            default: seg_d = SEG_OFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg        <= SEG_OFF;
         an         <= 3'b111;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_d;
         an         <= an_d;
         frame_done <= frame_end;
      end
   end

   // A load on the boundary cycle goes straight to the active set, so it is never left pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh      <= '{p2: SEG_OFF, p1: SEG_OFF, p0: SEG_OFF};
         ac      <= '{p2: SEG_OFF, p1: SEG_OFF, p0: SEG_OFF};
         pending <= 1'b0;
      end else if (load && !en) begin
         sh      <= din;
         ac      <= din;
         pending <= 1'b0;
      end else begin
         if (load) begin
            sh      <= din;
            pending <= 1'b1;
         end
         if (frame_end) begin
            ac      <= load ? din : sh;
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner at TICK_DIV=8, BLANK_CYC=2.
module tb_seg_display_scanner;

   localparam int TD = 8;
   localparam int BC = 2;
   localparam int FRAME = 3 * TD;

   logic       clk = 1'b0;
   logic       rst, en, lzb, load;
   logic [7:0] d2, d1, d0;
   logic [7:0] seg;
   logic [2:0] an;
   logic       frame_done, pending;

   int checks = 0;
   int failures = 0;

   // Reference state: s is the scan index after the last edge (-1 when idle).
   int         s;
   logic [7:0] ex2, ex1, ex0, sh2, sh1, sh0;
   logic       pend;

   always #5 clk = ~clk;

   seg_display_scanner #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .lzb        (lzb),
      .load       (load),
      .d2         (d2),
      .d1         (d1),
      .d0         (d0),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done),
      .pending    (pending)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic step();
      int         so, sl;
      logic [7:0] es;
      logic [2:0] ea;
      logic       ef;
      so = s;
      es = 8'hFF;
      ea = 3'b111;
      ef = 1'b0;
      @(posedge clk);
      #1;
      if (rst) begin
         s = -1;
         {ex2, ex1, ex0, sh2, sh1, sh0} = {6{8'hFF}};
         pend = 1'b0;
      end else begin
         if (so >= 0) begin
            sl = (so / TD) % 3;
            if ((so % TD) >= BC) begin
               ea = ~(3'b001 << sl);
               case (sl)
                  0:       es = ex0;
                  1:       es = (lzb && ex2 == 8'hC0 && ex1 == 8'hC0) ? 8'hFF : ex1;
                  default: es = (lzb && ex2 == 8'hC0) ? 8'hFF : ex2;
               endcase
            end
            ef = ((so % FRAME) == FRAME - 1) && en;
         end
         if (load) begin
            {sh2, sh1, sh0} = {d2, d1, d0};
            if (en) pend = 1'b1;
            else begin
               {ex2, ex1, ex0} = {d2, d1, d0};
               pend = 1'b0;
            end
         end
         if (ef) begin
            {ex2, ex1, ex0} = {sh2, sh1, sh0};
            pend = 1'b0;
         end
         s = !en ? -1 : (so < 0 ? 0 : so + 1);
      end
      check_val("seg", 32'(seg), 32'(es));
      check_val("an", 32'(an), 32'(ea));
      check_val("frame_done", 32'(frame_done), 32'(ef));
      check_val("pending", 32'(pending), 32'(pend));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic load_pat(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
      {d2, d1, d0} = {a2, a1, a0};
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; lzb = 1'b0; load = 1'b0;
      d2 = 8'h00; d1 = 8'h00; d0 = 8'h00;
      s = -1; pend = 1'b0;
      {ex2, ex1, ex0, sh2, sh1, sh0} = {6{8'hFF}};
      #2;
      run(2);
      rst = 1'b0;
      run(1);

      // Scan with reset patterns: blanking and digit-enable timing, frame_done cadence
      en = 1'b1;
      run(50);
      en = 1'b0;
      run(3);

      // Load while disabled goes straight to the active set
      load_pat(8'hF9, 8'hA4, 8'hC0);
      en = 1'b1;
      run(26);

      // Mid-slot-1 load is held until the frame boundary
      run(10);
      load_pat(8'hB0, 8'h99, 8'h92);
      run(24);

      // Two loads in one frame: the latest wins
      load_pat(8'h80, 8'h80, 8'h80);
      run(3);
      load_pat(8'h82, 8'hF8, 8'h90);
      run(30);

      // Load on the boundary cycle itself
      check_val("boundary_align", 32'(s % FRAME), 32'(FRAME - 1));
      load_pat(8'h88, 8'h83, 8'hC6);
      run(12);

      // Leading-zero blanking
      lzb = 1'b1;
      en = 1'b0;
      run(2);
      load_pat(8'hC0, 8'hC0, 8'hF9);
      en = 1'b1;
      run(26);
      en = 1'b0;
      run(2);
      load_pat(8'hC0, 8'hF9, 8'hC0);
      en = 1'b1;
      run(26);

      // Reset mid-frame with a pending load discards everything
      lzb = 1'b0;
      run(10);
      load_pat(8'h86, 8'h8E, 8'hA1);
      run(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
